// File: rtl/ota_trim_cal_ctrl_if.sv
// Control/status bundle between the pin-side controller and the OTA trim sequencer.
interface ota_trim_cal_ctrl_if #(
  parameter int TRIM_W = 6
) ();
  logic              start;
  logic              abort;
  logic              cmp_in;
  logic              man_en;
  logic [TRIM_W-1:0] man_code;
  logic [TRIM_W-1:0] trim_code;
  logic              cal_en;
  logic              busy;
  logic              done;
  logic              trim_valid;

  // Controller side: issues commands, observes trim status
  modport master (
    output start, abort, cmp_in, man_en, man_code,
    input  trim_code, cal_en, busy, done, trim_valid
  );

  // Sequencer side
  modport slave (
    input  start, abort, cmp_in, man_en, man_code,
    output trim_code, cal_en, busy, done, trim_valid
  );
endinterface

// File: rtl/ota_trim_cal_ctrl.sv
// OTA offset-trim calibration sequencer: SAR search on the OTA comparator with
// per-bit settle time and majority-voted sampling, plus a manual code override.
module ota_trim_cal_ctrl #(
  parameter int TRIM_W     = 6,
  parameter int SETTLE_CYC = 16,
  parameter int N_SAMP     = 3
) (
  input  logic               clk,
  input  logic               rst,
  ota_trim_cal_ctrl_if.slave bus
);

  localparam int IDX_W  = (TRIM_W > 2) ? $clog2(TRIM_W) : 1;
  localparam int CNT_MX = (SETTLE_CYC > N_SAMP) ? SETTLE_CYC : N_SAMP;
  localparam int CNT_W  = $clog2(CNT_MX + 1);
  localparam int ONES_W = $clog2(N_SAMP + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SAMP_LAST   = CNT_W'(N_SAMP - 1);
  localparam logic [ONES_W-1:0] HALF_SAMP   = ONES_W'(N_SAMP / 2);
  localparam logic [IDX_W-1:0]  TOP_IDX     = IDX_W'(TRIM_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic [TRIM_W-1:0] last_good_q, last_good_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic              cal_en_q, cal_en_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              cmp_s1_q, cmp_s2_q;

  // Next-state and datapath decisions for the SAR sequencer
  always_comb begin
    state_d     = state_q;
    trim_d      = trim_q;
    last_good_d = last_good_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    cal_en_d    = cal_en_q;
    valid_d     = valid_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.man_en) begin
          // Manual code is tracked continuously and becomes the abort fallback
          trim_d      = bus.man_code;
          last_good_d = bus.man_code;
          valid_d     = 1'b1;
        end else if (bus.start && !bus.abort) begin
          idx_d    = TOP_IDX;
          trim_d   = {1'b1, {(TRIM_W-1){1'b0}}};
          cal_en_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        ones_d = ones_q + ONES_W'(cmp_s2_q);
        if (cnt_q == SAMP_LAST) begin
          cnt_d   = '0;
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECIDE: begin
        // Comparator low on the majority means the trial code overshot
        if (ones_q <= HALF_SAMP) trim_d[idx_q] = 1'b0;
        if (idx_q != '0) begin
          trim_d[idx_q - IDX_W'(1)] = 1'b1;
          idx_d   = idx_q - IDX_W'(1);
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d      = 1'b1;
        cal_en_d    = 1'b0;
        valid_d     = 1'b1;
        last_good_d = trim_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort discards the partial search and restores the last good code
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      trim_d      = last_good_q;
      last_good_d = last_good_q;
      cal_en_d    = 1'b0;
      valid_d     = valid_q;
      done_d      = 1'b0;
      cnt_d       = '0;
    end
  end

  // State, datapath and comparator synchronizer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      trim_q      <= '0;
      last_good_q <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ones_q      <= '0;
      cal_en_q    <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      cmp_s1_q    <= 1'b0;
      cmp_s2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      trim_q      <= trim_d;
      last_good_q <= last_good_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      cal_en_q    <= cal_en_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      cmp_s1_q    <= bus.cmp_in;
      cmp_s2_q    <= cmp_s1_q;
    end
  end

  assign bus.trim_code  = trim_q;
  assign bus.cal_en     = cal_en_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.trim_valid = valid_q;

endmodule

// File: tb/tb_ota_trim_cal_ctrl.sv
// Directed bench for the OTA trim calibration sequencer.
module tb_ota_trim_cal_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  int       mode = 0;        // 0: cmp=(trim<=target), 1: stuck 1, 2: stuck 0
  logic [5:0] target = 6'd37;
  logic     glitch = 1'b0;
  bit       glitch_en = 1'b0;

  ota_trim_cal_ctrl_if #(.TRIM_W(6)) bus ();

  ota_trim_cal_ctrl #(.TRIM_W(6), .SETTLE_CYC(16), .N_SAMP(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.cmp_in = glitch ^ ((mode == 1) ? 1'b1 :
                                (mode == 2) ? 1'b0 : (bus.trim_code <= target));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Full calibration from IDLE, checking trial MSB, latency and final state
  task automatic run_cal(input string name, input logic [5:0] exp_code);
    int lat = 0;
    bit seen = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({name, "_busy"}, {7'd0, bus.busy}, 8'd1);
    chk({name, "_msb"}, {2'd0, bus.trim_code}, 8'd32);
    chk({name, "_calen"}, {7'd0, bus.cal_en}, 8'd1);
    for (int c = 0; c < 200 && !seen; c++) begin
      glitch = glitch_en && ((c % 20) == 15);
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1;
    end
    glitch = 1'b0;
    chk({name, "_done_seen"}, {7'd0, seen}, 8'd1);
    chk({name, "_latency"}, 8'(lat), 8'd121);
    chk({name, "_code"}, {2'd0, bus.trim_code}, {2'd0, exp_code});
    chk({name, "_valid"}, {7'd0, bus.trim_valid}, 8'd1);
    chk({name, "_calen_off"}, {7'd0, bus.cal_en}, 8'd0);
    chk({name, "_busy_off"}, {7'd0, bus.busy}, 8'd0);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, {7'd0, bus.done}, 8'd0);
    $display("run %s: code=%0d latency=%0d", name, bus.trim_code, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    chk("rst_code", {2'd0, bus.trim_code}, 8'd0);
    chk("rst_calen", {7'd0, bus.cal_en}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_done", {7'd0, bus.done}, 8'd0);
    chk("rst_valid", {7'd0, bus.trim_valid}, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    $display("test_reset: outputs cleared");
  endtask

  task automatic test_manual();
    bus.man_en = 1'b1;
    bus.man_code = 6'd12;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("man_code", {2'd0, bus.trim_code}, 8'd12);
    chk("man_valid", {7'd0, bus.trim_valid}, 8'd1);
    chk("man_start_ign", {7'd0, bus.busy}, 8'd0);
    @(posedge clk); #1;
    chk("man_start_ign2", {7'd0, bus.busy}, 8'd0);
    bus.man_en = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    chk("start_abort_idle", {7'd0, bus.busy}, 8'd0);
    chk("start_abort_code", {2'd0, bus.trim_code}, 8'd12);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(posedge clk); #1;
    $display("test_manual: code=%0d busy=%0d", bus.trim_code, bus.busy);
  endtask

  task automatic test_nominal();
    mode = 0; target = 6'd37;
    run_cal("t1", 6'd37);
  endtask

  task automatic test_stuck();
    mode = 1;
    run_cal("stuck1", 6'd63);
    mode = 2;
    run_cal("stuck0", 6'd0);
    mode = 0;
  endtask

  task automatic test_abort();
    int dcount = 0;
    mode = 0; target = 6'd37;
    run_cal("pre_abort", 6'd37);
    target = 6'd10;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // cycle 0 now; bit index 3 samples in cycles 56..58
    for (int c = 0; c < 57; c++) begin
      @(posedge clk); #1;
      if (bus.done) dcount++;
    end
    chk("abort_busy_before", {7'd0, bus.busy}, 8'd1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_idle", {7'd0, bus.busy}, 8'd0);
    chk("abort_code", {2'd0, bus.trim_code}, 8'd37);
    chk("abort_calen", {7'd0, bus.cal_en}, 8'd0);
    chk("abort_valid", {7'd0, bus.trim_valid}, 8'd1);
    for (int c = 0; c < 30; c++) begin
      if (bus.done) dcount++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 8'(dcount), 8'd0);
    target = 6'd37;
    $display("test_abort: code=%0d done_pulses=%0d", bus.trim_code, dcount);
  endtask

  task automatic test_glitch();
    mode = 0; target = 6'd21;
    glitch_en = 1'b1;
    run_cal("glitch", 6'd21);
    glitch_en = 1'b0;
  endtask

  task automatic test_midreset();
    mode = 0; target = 6'd37;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_code", {2'd0, bus.trim_code}, 8'd0);
    chk("mrst_calen", {7'd0, bus.cal_en}, 8'd0);
    chk("mrst_busy", {7'd0, bus.busy}, 8'd0);
    chk("mrst_done", {7'd0, bus.done}, 8'd0);
    chk("mrst_valid", {7'd0, bus.trim_valid}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("test_midreset: cleared, restarting");
    run_cal("after_rst", 6'd37);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.man_en = 1'b0;
    bus.man_code = '0;
    test_reset();
    test_manual();
    test_nominal();
    test_stuck();
    test_abort();
    test_glitch();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
